// File: rtl/round_robin_arbiter_pkg.sv
// arb_pkg: shared state encoding and one-hot helper for the arbiter
package arb_pkg;
  localparam int MAX_W = 8;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  function automatic logic [MAX_W-1:0] onehot(input logic [2:0] idx);
    return MAX_W'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotated priority encoder, first set cand bit scanning from start (or from 0 when fixed)
module rr_pick #(
  parameter int W = 4,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  cand,
  input  logic [IW-1:0] start,
  input  logic          fixed,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    int p;
    any = 1'b0;
    idx = '0;
    p = 0;
    for (int i = 0; i < W; i++) begin
      p = (i + (fixed ? 0 : int'(start))) % W;
      if (cand[p]) begin
        any = 1'b1;
        idx = IW'(p);
        break;
      end
    end
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: single-owner arbiter with fixed/round-robin selection and a hold limit
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int W = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = $clog2(W),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  req,
  input  logic          done,
  input  logic          fixed_prio,
  output logic [W-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);
  arb_state_t state, state_d;
  logic [W-1:0] grant_d, cand;
  logic [IW-1:0] id_d, last, last_d, start, idx;
  logic [HW-1:0] hold_cnt, hold_d;
  logic rel, go, any;
  assign rel = done | ~req[grant_id] | (hold_cnt == HW'(MAX_HOLD));
  assign go = (state == IDLE) | rel;
  // the outgoing owner never competes for its own handover
  assign cand = (state == BUSY) ? (req & ~grant) : req;
  assign start = (last == IW'(W - 1)) ? '0 : last + 1'b1;
  rr_pick #(.W(W)) u_pick (
    .cand (cand),
    .start(start),
    .fixed(fixed_prio),
    .any  (any),
    .idx  (idx)
  );
  always_comb begin
    state_d = state;
    grant_d = grant;
    id_d = grant_id;
    last_d = last;
    hold_d = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
    if (go) begin
      state_d = any ? BUSY : IDLE;
      grant_d = any ? W'(onehot(3'(idx))) : '0;
      id_d = any ? idx : '0;
      last_d = any ? idx : last;
      hold_d = any ? HW'(1) : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_valid <= 1'b0;
      grant_id <= '0;
      last <= IW'(W - 1);
      hold_cnt <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      grant_valid <= |grant_d;
      grant_id <= id_d;
      last <= last_d;
      hold_cnt <= hold_d;
    end
  end
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed vectors with hand-computed grants plus per-cycle invariants
module tb_round_robin_arbiter;
  logic clk = 1'b0, rst = 1'b1, done = 1'b0, fixed_prio = 1'b0;
  logic [3:0] req = '0, grant;
  logic grant_valid;
  logic [1:0] grant_id;
  int n_run = 0, n_fail = 0;
  round_robin_arbiter #(.W(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .fixed_prio(fixed_prio),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction
  task automatic expect_grant(input string tag, input logic [3:0] g);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_id"}, 32'(grant_id), 32'(enc(g)));
    chk({tag, "_valid"}, 32'(grant_valid), 32'(|g));
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
    chk("inv_valid", 32'(grant_valid), 32'(|grant));
    chk("inv_id", 32'(grant_id), 32'(enc(grant)));
  end
  initial begin
    #1;
    expect_grant("reset", 4'b0000);
    cyc;
    cyc;
    rst = 1'b0;
    cyc;
    expect_grant("idle", 4'b0000);
    fixed_prio = 1'b1;
    req = 4'b1100;
    cyc;
    expect_grant("fixed_first", 4'b0100);
    done = 1'b1;
    cyc;
    expect_grant("fixed_done", 4'b1000);
    done = 1'b0;
    req = 4'b0000;
    cyc;
    expect_grant("fixed_idle", 4'b0000);
    req = 4'b0010;
    cyc;
    expect_grant("pre_reset", 4'b0010);
    #2 rst = 1'b1;
    #1 expect_grant("async_reset", 4'b0000);
    req = 4'b0000;
    cyc;
    rst = 1'b0;
    begin
      logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      fixed_prio = 1'b0;
      req = 4'b1111;
      cyc;
      expect_grant("rr_0", order[0]);
      for (int k = 1; k < 5; k++) begin
        cyc;
        expect_grant("rr_hold", order[k-1]);
        done = 1'b1;
        cyc;
        expect_grant("rr_next", order[k]);
        done = 1'b0;
      end
    end
    req = 4'b0000;
    cyc;
    expect_grant("rr_idle", 4'b0000);
    fixed_prio = 1'b1;
    req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      cyc;
      expect_grant("hold_own0", 4'b0001);
    end
    for (int i = 0; i < 8; i++) begin
      cyc;
      expect_grant("hold_own1", 4'b0010);
    end
    cyc;
    expect_grant("hold_back0", 4'b0001);
    req = 4'b0000;
    cyc;
    expect_grant("hold_idle", 4'b0000);
    fixed_prio = 1'b0;
    req = 4'b0001;
    cyc;
    expect_grant("sole_grant", 4'b0001);
    done = 1'b1;
    cyc;
    expect_grant("sole_gap", 4'b0000);
    done = 1'b0;
    cyc;
    expect_grant("sole_regrant", 4'b0001);
    req = 4'b0000;
    cyc;
    expect_grant("sole_idle", 4'b0000);
    fixed_prio = 1'b1;
    req = 4'b0100;
    cyc;
    expect_grant("drop_owner2", 4'b0100);
    fixed_prio = 1'b0;
    req = 4'b0001;
    cyc;
    expect_grant("drop_move0", 4'b0001);
    req = 4'b0000;
    cyc;
    expect_grant("drop_idle", 4'b0000);
    fixed_prio = 1'b1;
    req = 4'b0100;
    cyc;
    expect_grant("drop2_owner2", 4'b0100);
    fixed_prio = 1'b0;
    req = 4'b1001;
    cyc;
    expect_grant("drop2_rr3", 4'b1000);
    req = 4'b0000;
    cyc;
    expect_grant("final_idle", 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
